// File: rtl/ps2_text_cursor_writer_if.sv
// Bus between the PS/2 ASCII decoder and the text cursor writer: strobe in, RAM write port and
// cursor/status outputs back.
interface ps2_text_cursor_writer_if #(
   parameter int unsigned COLS   = 16,
   parameter int unsigned ROWS   = 12,
   parameter int unsigned ADDR_W = 8
);
   logic [7:0]              iascii;
   logic                    iascii_valid;
   logic                    oready;
   logic                    odropped;
   logic [ADDR_W-1:0]       oram_addr;
   logic [7:0]              oram_data;
   logic                    oram_wen;
   logic [$clog2(COLS)-1:0] ocol;
   logic [$clog2(ROWS)-1:0] orow;
   logic [9:0]              ocur_x;
   logic [9:0]              ocur_y;
   logic [3:0]              odigit;
   logic [15:0]             ochar_count;

   modport master (
      output iascii, iascii_valid,
      input  oready, odropped, oram_addr, oram_data, oram_wen, ocol, orow, ocur_x, ocur_y,
             odigit, ochar_count
   );

   modport slave (
      input  iascii, iascii_valid,
      output oready, odropped, oram_addr, oram_data, oram_wen, ocol, orow, ocur_x, ocur_y,
             odigit, ochar_count
   );
endinterface

// File: rtl/ps2_text_cursor_writer.sv
// Text cursor + screen-RAM writer fed by decoded PS/2 ASCII strobes.
// Define PS2_SCREEN_CLEAR_EN to blank the screen instead of wrapping past the last row.
module ps2_text_cursor_writer #(
   parameter int unsigned COLS   = 16,
   parameter int unsigned ROWS   = 12,
   parameter int unsigned CELL_W = 40,
   parameter int unsigned CELL_H = 40,
   parameter int unsigned ADDR_W = 8
) (
   input logic                     iCLK,
   input logic                     iRST_N,
   ps2_text_cursor_writer_if.slave bus
);

   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned ROW_W = $clog2(ROWS);

   localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);
   localparam logic [9:0]        X_STEP  = 10'(CELL_W);
   localparam logic [9:0]        Y_STEP  = 10'(CELL_H);
   localparam logic [9:0]        X_LAST  = 10'((COLS - 1) * CELL_W);
   localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_COLS  = ADDR_W'(COLS);
`ifdef PS2_SCREEN_CLEAR_EN
   localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(COLS * ROWS - 1);
`endif

   if (COLS < 2 || ROWS < 2) begin : g_bad_dims
      $error("ps2_text_cursor_writer: COLS and ROWS must both be at least 2");
   end
   if (64'(COLS) * 64'(ROWS) > (64'(1) << ADDR_W)) begin : g_bad_addr
      $error("ps2_text_cursor_writer: COLS*ROWS does not fit in ADDR_W address bits");
   end

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StAdvance
`ifdef PS2_SCREEN_CLEAR_EN
      , StClear
`endif
   } state_e;

   state_e            state_q;
   logic              ready_q;
   logic              wen_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [7:0]        ram_data_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [9:0]        x_q;
   logic [9:0]        y_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        digit_q;
   logic [15:0]       count_q;
   logic              bs_q;
   logic              nl_q;
   logic [COL_W-1:0]  tgt_col_q;
   logic [ROW_W-1:0]  tgt_row_q;
   logic [9:0]        tgt_x_q;
   logic [9:0]        tgt_y_q;

   logic              accept;
   logic              is_print;
   logic              is_nl;
   logic              is_bs;
   logic              is_digit;
   logic              last_col;
   logic              last_row;
   logic [COL_W-1:0]  bs_col;
   logic [ROW_W-1:0]  bs_row;
   logic [9:0]        bs_x;
   logic [9:0]        bs_y;
   logic [ADDR_W-1:0] bs_addr;

   always_comb begin
      accept   = bus.iascii_valid & ready_q;
      is_print = (bus.iascii >= 8'h20) && (bus.iascii <= 8'h7E);
      is_nl    = (bus.iascii == 8'h0A) || (bus.iascii == 8'h0D);
      is_bs    = (bus.iascii == 8'h08);
      is_digit = (bus.iascii >= 8'h30) && (bus.iascii <= 8'h39);
      last_col = (col_q == COL_MAX);
      last_row = (row_q == ROW_MAX);
   end

   // Backspace target: step left, back up to the end of the previous row, or pin at (0,0).
   always_comb begin
      bs_col  = '0;
      bs_row  = '0;
      bs_x    = '0;
      bs_y    = '0;
      bs_addr = '0;
      if (col_q != '0) begin
         bs_col  = col_q - COL_W'(1);
         bs_row  = row_q;
         bs_x    = x_q - X_STEP;
         bs_y    = y_q;
         bs_addr = addr_q - A_ONE;
      end else if (row_q != '0) begin
         bs_col  = COL_MAX;
         bs_row  = row_q - ROW_W'(1);
         bs_x    = X_LAST;
         bs_y    = y_q - Y_STEP;
         bs_addr = addr_q - A_ONE;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= StIdle;
         ready_q    <= 1'b1;
         wen_q      <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         addr_q     <= '0;
         digit_q    <= '0;
         count_q    <= '0;
         bs_q       <= 1'b0;
         nl_q       <= 1'b0;
         tgt_col_q  <= '0;
         tgt_row_q  <= '0;
         tgt_x_q    <= '0;
         tgt_y_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept && is_print) begin
                  state_q    <= StWrite;
                  ready_q    <= 1'b0;
                  wen_q      <= 1'b1;
                  ram_addr_q <= addr_q;
                  ram_data_q <= bus.iascii;
                  bs_q       <= 1'b0;
                  nl_q       <= 1'b0;
                  digit_q    <= is_digit ? bus.iascii[3:0] : 4'd0;
                  if (count_q != 16'hFFFF) begin
                     count_q <= count_q + 16'd1;
                  end
               end else if (accept && is_bs) begin
                  state_q    <= StWrite;
                  ready_q    <= 1'b0;
                  wen_q      <= 1'b1;
                  ram_addr_q <= bs_addr;
                  ram_data_q <= 8'h20;
                  bs_q       <= 1'b1;
                  nl_q       <= 1'b0;
                  tgt_col_q  <= bs_col;
                  tgt_row_q  <= bs_row;
                  tgt_x_q    <= bs_x;
                  tgt_y_q    <= bs_y;
               end else if (accept && is_nl) begin
                  state_q <= StAdvance;
                  ready_q <= 1'b0;
                  bs_q    <= 1'b0;
                  nl_q    <= 1'b1;
               end
            end

            StWrite: begin
               wen_q   <= 1'b0;
               state_q <= StAdvance;
               if (bs_q) begin
                  col_q  <= tgt_col_q;
                  row_q  <= tgt_row_q;
                  x_q    <= tgt_x_q;
                  y_q    <= tgt_y_q;
                  addr_q <= ram_addr_q;
               end else if (!last_col) begin
                  col_q  <= col_q + COL_W'(1);
                  x_q    <= x_q + X_STEP;
                  addr_q <= addr_q + A_ONE;
               end else if (!last_row) begin
                  col_q  <= '0;
                  x_q    <= '0;
                  row_q  <= row_q + ROW_W'(1);
                  y_q    <= y_q + Y_STEP;
                  addr_q <= addr_q + A_ONE;
               end else begin
`ifdef PS2_SCREEN_CLEAR_EN
                  state_q    <= StClear;
                  wen_q      <= 1'b1;
                  ram_addr_q <= '0;
                  ram_data_q <= 8'h20;
`else
                  col_q  <= '0;
                  row_q  <= '0;
                  x_q    <= '0;
                  y_q    <= '0;
                  addr_q <= '0;
`endif
               end
            end

            StAdvance: begin
               nl_q <= 1'b0;
               if (nl_q && last_row) begin
`ifdef PS2_SCREEN_CLEAR_EN
                  state_q    <= StClear;
                  wen_q      <= 1'b1;
                  ram_addr_q <= '0;
                  ram_data_q <= 8'h20;
`else
                  col_q   <= '0;
                  row_q   <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  addr_q  <= '0;
                  state_q <= StIdle;
                  ready_q <= 1'b1;
`endif
               end else begin
                  if (nl_q) begin
                     col_q  <= '0;
                     x_q    <= '0;
                     row_q  <= row_q + ROW_W'(1);
                     y_q    <= y_q + Y_STEP;
                     // Start of next row without a multiplier: addr - col + COLS.
                     addr_q <= addr_q + A_COLS - ADDR_W'(col_q);
                  end
                  state_q <= StIdle;
                  ready_q <= 1'b1;
               end
            end

`ifdef PS2_SCREEN_CLEAR_EN
            StClear: begin
               if (ram_addr_q == A_LAST) begin
                  wen_q   <= 1'b0;
                  col_q   <= '0;
                  row_q   <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  addr_q  <= '0;
                  state_q <= StIdle;
                  ready_q <= 1'b1;
               end else begin
                  ram_addr_q <= ram_addr_q + A_ONE;
               end
            end
`endif

            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
               wen_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oready      = ready_q;
   assign bus.odropped    = bus.iascii_valid & ~ready_q;
   assign bus.oram_addr   = ram_addr_q;
   assign bus.oram_data   = ram_data_q;
   assign bus.oram_wen    = wen_q;
   assign bus.ocol        = col_q;
   assign bus.orow        = row_q;
   assign bus.ocur_x      = x_q;
   assign bus.ocur_y      = y_q;
   assign bus.odigit      = digit_q;
   assign bus.ochar_count = count_q;

endmodule

// File: tb/tb_ps2_text_cursor_writer.sv
// Bench for ps2_text_cursor_writer: timeline model of expected per-cycle outputs plus
// hand-computed pins. Honours PS2_SCREEN_CLEAR_EN the same way as the design.
module tb_ps2_text_cursor_writer;
   localparam int COLS   = 16;
   localparam int ROWS   = 12;
   localparam int CELL_W = 40;
   localparam int CELL_H = 40;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ps2_text_cursor_writer_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus ();

   ps2_text_cursor_writer #(
      .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H), .ADDR_W(ADDR_W)
   ) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .bus   (bus)
   );

   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   // Expected outputs for each cycle the block is busy; empty queue means idle.
   typedef struct {
      bit wen;
      int addr;
      int data;
      int col;
      int row;
   } rec_t;

   rec_t q[$];
   int   mcol = 0, mrow = 0, mdigit = 0, mcount = 0;

   task automatic push_clear(input int oc, input int orr);
`ifdef PS2_SCREEN_CLEAR_EN
      for (int a = 0; a < COLS * ROWS; a++) q.push_back('{1'b1, a, 32, oc, orr});
`endif
   endtask

   task automatic accept_model(input int c);
      int oc = mcol;
      int orr = mrow;
      bit clear_on = 1'b0;
`ifdef PS2_SCREEN_CLEAR_EN
      clear_on = 1'b1;
`endif
      if (c >= 32 && c <= 126) begin
         mdigit = (c >= 48 && c <= 57) ? c - 48 : 0;
         if (mcount < 65535) mcount++;
         q.push_back('{1'b1, orr * COLS + oc, c, oc, orr});
         if (oc < COLS - 1) begin
            mcol = oc + 1;
         end else if (orr < ROWS - 1) begin
            mcol = 0;
            mrow = orr + 1;
         end else begin
            mcol = 0;
            mrow = 0;
            if (clear_on) push_clear(oc, orr);
         end
         if (!(clear_on && oc == COLS - 1 && orr == ROWS - 1))
            q.push_back('{1'b0, 0, 0, mcol, mrow});
      end else if (c == 10 || c == 13) begin
         q.push_back('{1'b0, 0, 0, oc, orr});
         if (orr == ROWS - 1 && clear_on) push_clear(oc, orr);
         mcol = 0;
         mrow = (orr < ROWS - 1) ? orr + 1 : 0;
      end else if (c == 8) begin
         if (oc > 0) begin
            mcol = oc - 1;
         end else if (orr > 0) begin
            mcol = COLS - 1;
            mrow = orr - 1;
         end
         q.push_back('{1'b1, mrow * COLS + mcol, 32, oc, orr});
         q.push_back('{1'b0, 0, 0, mcol, mrow});
      end
   endtask

   always @(negedge clk) begin : model_cmp
      rec_t e;
      bit   busy;
      if (!rst_n) begin
         q.delete();
         mcol = 0;
         mrow = 0;
         mdigit = 0;
         mcount = 0;
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         busy = 1'b1;
      end else begin
         e = '{1'b0, 0, 0, mcol, mrow};
         busy = 1'b0;
      end
      check("oready", bus.oready, !busy);
      check("odropped", bus.odropped, bus.iascii_valid && busy);
      check("oram_wen", bus.oram_wen, e.wen);
      if (e.wen) begin
         check("oram_addr", bus.oram_addr, e.addr);
         check("oram_data", bus.oram_data, e.data);
      end
      if (!rst_n) begin
         check("rst_addr", bus.oram_addr, 0);
         check("rst_data", bus.oram_data, 0);
      end
      check("ocol", bus.ocol, e.col);
      check("orow", bus.orow, e.row);
      check("ocur_x", bus.ocur_x, e.col * CELL_W);
      check("ocur_y", bus.ocur_y, e.row * CELL_H);
      check("odigit", bus.odigit, mdigit);
      check("ochar_count", bus.ochar_count, mcount);
      if (rst_n && bus.iascii_valid && !busy) accept_model(int'(bus.iascii));
   end

   task automatic strobe(input logic [7:0] c);
      @(posedge clk);
      #1;
      bus.iascii = c;
      bus.iascii_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.iascii_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.oready) break;
      end
      check("idle_reached", bus.oready, 1);
   endtask

   task automatic type_n(input int n);
      for (int i = 0; i < n; i++) begin
         strobe(8'(8'h61 + (i % 26)));
         wait_idle();
      end
   endtask

   task automatic newlines(input int n);
      for (int i = 0; i < n; i++) begin
         strobe(8'h0A);
         wait_idle();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pin_write(input int a, input int d);
      @(negedge clk);
      check("pin_wen", bus.oram_wen, 1);
      check("pin_addr", bus.oram_addr, a);
      check("pin_data", bus.oram_data, d);
   endtask

   task automatic pin_cursor(input int c, input int r);
      check("pin_col", bus.ocol, c);
      check("pin_row", bus.orow, r);
      check("pin_x", bus.ocur_x, c * 40);
      check("pin_y", bus.ocur_y, r * 40);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw;
      int good;
      bus.iascii = 8'h00;
      bus.iascii_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 'A' from reset: write at 0, cursor to col 1 two cycles after accept.
      strobe(8'h41);
      pin_write(0, 8'h41);
      @(negedge clk);
      check("pin_col_n2", bus.ocol, 1);
      check("pin_x_n2", bus.ocur_x, 40);
      wait_idle();
      check("pin_count1", bus.ochar_count, 1);
      check("pin_digit0", bus.odigit, 0);

      // '7' in the last column wraps to the next row.
      type_n(14);
      strobe(8'h37);
      pin_write(15, 8'h37);
      wait_idle();
      pin_cursor(0, 1);
      check("pin_digit7", bus.odigit, 7);
      check("pin_count16", bus.ochar_count, 16);

      // Backspace inside a row, across a row, and at the origin.
      do_reset();
      newlines(2);
      type_n(3);
      strobe(8'h08);
      pin_write(34, 8'h20);
      wait_idle();
      pin_cursor(2, 2);

      do_reset();
      strobe(8'h0D);
      wait_idle();
      strobe(8'h08);
      pin_write(15, 8'h20);
      wait_idle();
      pin_cursor(15, 0);

      do_reset();
      strobe(8'h08);
      pin_write(0, 8'h20);
      wait_idle();
      pin_cursor(0, 0);

      // Newline from the last row.
      do_reset();
      newlines(11);
      type_n(5);
      strobe(8'h0D);
      @(negedge clk);
      check("pin_nl_nowen", bus.oram_wen, 0);
`ifdef PS2_SCREEN_CLEAR_EN
      nw = 0;
      good = 0;
      for (int i = 0; i < 400 && !bus.oready; i++) begin
         @(negedge clk);
         if (bus.oram_wen) begin
            if (bus.oram_addr == ADDR_W'(nw) && bus.oram_data == 8'h20) good++;
            nw++;
         end
      end
      check("pin_clear_writes", nw, 192);
      check("pin_clear_good", good, 192);
      check("pin_clear_ready", bus.oready, 1);
`else
      wait_idle();
`endif
      pin_cursor(0, 0);

      // Printable wrap off the bottom-right cell.
      do_reset();
      newlines(11);
      type_n(16);
      wait_idle();
      pin_cursor(0, 0);

      // Second strobe while busy is dropped.
      do_reset();
      @(posedge clk);
      #1;
      bus.iascii = 8'h41;
      bus.iascii_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.iascii = 8'h42;
      @(negedge clk);
      check("pin_dropped", bus.odropped, 1);
      check("pin_drop_data", bus.oram_data, 8'h41);
      @(posedge clk);
      #1 bus.iascii_valid = 1'b0;
      wait_idle();
      check("pin_drop_count", bus.ochar_count, 1);
      pin_cursor(1, 0);

      // Ignored control code.
      strobe(8'h1B);
      @(negedge clk);
      check("pin_ign_ready", bus.oready, 1);
      check("pin_ign_wen", bus.oram_wen, 0);
      pin_cursor(1, 0);

      // Reset in the middle of a write.
      type_n(3);
      strobe(8'h55);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("pin_rst_wen", bus.oram_wen, 0);
      check("pin_rst_count", bus.ochar_count, 0);
      check("pin_rst_ready", bus.oready, 1);
      pin_cursor(0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      strobe(8'h41);
      pin_write(0, 8'h41);
      wait_idle();

`ifdef PS2_SCREEN_CLEAR_EN
      // Reset in the middle of a clear.
      do_reset();
      newlines(11);
      strobe(8'h0A);
      repeat (20) @(negedge clk);
      check("pin_mid_clear_wen", bus.oram_wen, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("pin_rstc_wen", bus.oram_wen, 0);
      pin_cursor(0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      strobe(8'h41);
      pin_write(0, 8'h41);
      wait_idle();
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
